nim_move_ctrl: RTL and testbench
================================

Name: nim_move_ctrl

Overview:
- Sequences player move entry for the Nim game from four debounced pushbutton levels (outputs of the per-button debouncers).
- Performs rising-edge detection and priority arbitration between simultaneous presses.
- Runs a select-pile / choose-count / issue FSM.
- Hands each completed move to the game-state logic over a valid/ready handshake and tracks whose turn it is.

Parameters:
- NUM_PILES, 3, number of piles (≥2).
- CNT_W, 4, width of a pile size and of a move count.
- MAX_TAKE, 7, maximum sticks removable per move (1..2^CNT_W-1).
- PILE_W, $clog2(NUM_PILES), pile index width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- btn_lvl  in  4  debounced levels: [0] pile-next, [1] take-more, [2] confirm, [3] cancel.
- pile_sizes  in  NUM_PILES*CNT_W  current pile sizes; pile i at [i*CNT_W +: CNT_W]. Changes only while state is SELECT.
- move_valid  out  1  move offered to game logic.
- move_ready  in  1  game logic accepts move.
- move_pile  out  PILE_W  pile of offered move.
- move_count  out  CNT_W  sticks to remove.
- sel_pile  out  PILE_W  currently highlighted pile (display).
- sel_count  out  CNT_W  currently chosen count (display).
- cur_player  out  1  player to move (0/1).
- game_over  out  1  all piles empty.

Behaviour:
- Reset (async, all registers):
  - state = SELECT.
  - sel_pile = 0, sel_count = 0, cur_player = 0, move_valid = 0, game_over = 0.
  - Edge register prev = 4'b1111, so buttons held through reset do not generate presses.
- Edge detection and arbitration:
  - press = btn_lvl & ~prev (combinational); prev <= btn_lvl on every edge in all states.
  - Priority when several presses occur in the same cycle: cancel > confirm > take > pile. Only the winner acts; the others are discarded, not queued.
  - A press acts at the same clock edge where btn_lvl is first sampled high.
- limit = min(pile_sizes[sel_pile], MAX_TAKE).
- SELECT:
  - pile press: sel_pile <= (sel_pile == NUM_PILES-1) ? 0 : sel_pile+1.
  - confirm: if the selected pile is nonzero and game_over = 0, go to COUNT with sel_count <= 1. Otherwise ignored.
  - take and cancel: no effect.
- COUNT:
  - take press: sel_count <= (sel_count == limit) ? 1 : sel_count+1 (wraps within 1..limit).
  - confirm: go to ISSUE; move_valid <= 1; move_pile <= sel_pile; move_count <= sel_count.
  - cancel: go to SELECT; sel_count <= 0.
  - pile press: ignored.
- ISSUE:
  - move_valid held high; move_pile and move_count stable until accepted.
  - All presses are ignored, including cancel.
  - On an edge where move_valid && move_ready: move_valid <= 0, cur_player toggles, sel_count <= 0, go to SELECT. sel_pile is unchanged.
  - Latency: the accept edge is the only edge on which a move is consumed. Exactly one move is issued per confirm.
- move_pile and move_count reset to 0 and hold their last values outside ISSUE.
- game_over is registered: game_over <= (all piles == 0), updated every cycle. While it is high, SELECT ignores confirm. cur_player then identifies the losing player (normal-play rule: the player who took the last stick wins).
- move_ready while move_valid = 0 has no effect.
- Reset asserted mid-move (any state) aborts the move. No move_valid is produced after release until a new full sequence completes.

Test Plan:
- Reset with btn_lvl = 4'b0100 held, release reset, keep held 10 cycles -> no transition, state SELECT, move_valid = 0.
- pile_sizes = {3,5,7} (pile0 = 3). Pile press ×2 -> sel_pile = 2. Pile press ×1 -> sel_pile = 0 (wrap).
- sel_pile = 0 (size 3). Confirm, then take ×3 -> sel_count sequence 1,2,3,1. Confirm -> move_valid = 1, move_pile = 0, move_count = 1.
- In ISSUE, hold move_ready = 0 for 5 cycles with presses on all buttons -> outputs unchanged. Then move_ready = 1 for one cycle -> move_valid = 0 next cycle, cur_player 0 → 1, sel_count = 0.
- Confirm and take rising in the same cycle while in COUNT -> confirm wins, ISSUE entered with the pre-press count. Cancel + confirm together -> returns to SELECT, no move.
- pile_sizes = 0 everywhere -> game_over = 1 one cycle later; confirm ignored. A pile 1 of size 0 with pile 0 nonzero: confirm on pile 1 -> stays in SELECT.

Source files
------------

// File: rtl/nim_move_ctrl.sv
// +-----------------------------------------------------------------------------+
// | nim_move_ctrl: Nim move entry sequencer (edge detect, arbitration, handshake)|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module nim_move_ctrl #(
  parameter int NUM_PILES = 3,
  parameter int CNT_W     = 4,
  parameter int MAX_TAKE  = 7,
  parameter int PILE_W    = $clog2(NUM_PILES)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [3:0]                 btn_lvl,
  input  logic [NUM_PILES*CNT_W-1:0] pile_sizes,
  output logic                       move_valid,
  input  logic                       move_ready,
  output logic [PILE_W-1:0]          move_pile,
  output logic [CNT_W-1:0]           move_count,
  output logic [PILE_W-1:0]          sel_pile,
  output logic [CNT_W-1:0]           sel_count,
  output logic                       cur_player,
  output logic                       game_over
);

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_COUNT  = 2'd1,
    S_ISSUE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  C_MAX_TAKE = CNT_W'(MAX_TAKE);
  localparam logic [PILE_W-1:0] C_LAST     = PILE_W'(NUM_PILES - 1);
  localparam logic [CNT_W-1:0]  C_ONE      = CNT_W'(1);

  state_t              r_state;
  logic [3:0]          r_prev;
  logic [PILE_W-1:0]   r_sel_pile;
  logic [CNT_W-1:0]    r_sel_count;
  logic                r_player;
  logic                r_valid;
  logic                r_game_over;
  logic [PILE_W-1:0]   r_move_pile;
  logic [CNT_W-1:0]    r_move_count;

  logic [CNT_W-1:0]    w_sizes [NUM_PILES];
  logic [CNT_W-1:0]    w_cur_size;
  logic [CNT_W-1:0]    w_limit;
  logic [3:0]          w_press;
  logic                w_do_cancel;
  logic                w_do_confirm;
  logic                w_do_take;
  logic                w_do_pile;
  logic                w_all_zero;

  for (genvar i = 0; i < NUM_PILES; i++) begin : g_unpack
    assign w_sizes[i] = pile_sizes[i*CNT_W +: CNT_W];
  end

  assign w_cur_size = w_sizes[r_sel_pile];
  assign w_limit    = (w_cur_size < C_MAX_TAKE) ? w_cur_size : C_MAX_TAKE;
  assign w_all_zero = (pile_sizes == '0);

  // Only the highest-priority rising edge acts; the rest are dropped.
  assign w_press      = btn_lvl & ~r_prev;
  assign w_do_cancel  = w_press[3];
  assign w_do_confirm = w_press[2] & ~w_press[3];
  assign w_do_take    = w_press[1] & ~w_press[2] & ~w_press[3];
  assign w_do_pile    = w_press[0] & ~w_press[1] & ~w_press[2] & ~w_press[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_SELECT;
      r_prev       <= 4'b1111;
      r_sel_pile   <= '0;
      r_sel_count  <= '0;
      r_player     <= 1'b0;
      r_valid      <= 1'b0;
      r_game_over  <= 1'b0;
      r_move_pile  <= '0;
      r_move_count <= '0;
    end else begin
      r_prev      <= btn_lvl;
      r_game_over <= w_all_zero;
      case (r_state)
        S_SELECT: begin
          if (w_do_confirm) begin
            if ((w_cur_size != '0) && !r_game_over) begin
              r_state     <= S_COUNT;
              r_sel_count <= C_ONE;
            end
          end else if (w_do_pile) begin
            r_sel_pile <= (r_sel_pile == C_LAST) ? '0 : r_sel_pile + 1'b1;
          end
        end
        S_COUNT: begin
          if (w_do_cancel) begin
            r_state     <= S_SELECT;
            r_sel_count <= '0;
          end else if (w_do_confirm) begin
            r_state      <= S_ISSUE;
            r_valid      <= 1'b1;
            r_move_pile  <= r_sel_pile;
            r_move_count <= r_sel_count;
          end else if (w_do_take) begin
            r_sel_count <= (r_sel_count >= w_limit) ? C_ONE : r_sel_count + 1'b1;
          end
        end
        S_ISSUE: begin
          if (move_ready) begin
            r_state     <= S_SELECT;
            r_valid     <= 1'b0;
            r_player    <= ~r_player;
            r_sel_count <= '0;
          end
        end
        default: begin
          r_state <= S_SELECT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign move_valid = r_valid;
  assign move_pile  = r_move_pile;
  assign move_count = r_move_count;
  assign sel_pile   = r_sel_pile;
  assign sel_count  = r_sel_count;
  assign cur_player = r_player;
  assign game_over  = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_nim_move_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_nim_move_ctrl: table-driven self-checking bench for nim_move_ctrl        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_nim_move_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  btn_lvl;
  logic [11:0] pile_sizes;
  logic        move_valid;
  logic        move_ready;
  logic [1:0]  move_pile;
  logic [3:0]  move_count;
  logic [1:0]  sel_pile;
  logic [3:0]  sel_count;
  logic        cur_player;
  logic        game_over;

  int n_checks;
  int n_fails;

  // {valid, sel_pile, sel_count, move_pile, move_count, cur_player, game_over}
  typedef struct packed {
    logic [3:0]  btn;
    logic        ready;
    logic [11:0] sizes;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  nim_move_ctrl #(.NUM_PILES(3), .CNT_W(4), .MAX_TAKE(7)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_lvl    (btn_lvl),
    .pile_sizes (pile_sizes),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_pile  (move_pile),
    .move_count (move_count),
    .sel_pile   (sel_pile),
    .sel_count  (sel_count),
    .cur_player (cur_player),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pack(input logic v, input logic [1:0] sp, input logic [3:0] sc,
                                       input logic [1:0] mp, input logic [3:0] mc,
                                       input logic pl, input logic go);
    return {v, sp, sc, mp, mc, pl, go};
  endfunction

  task automatic add(input logic [3:0] btn, input logic rdy, input logic [11:0] sz,
                     input logic v, input logic [1:0] sp, input logic [3:0] sc,
                     input logic [1:0] mp, input logic [3:0] mc, input logic pl, input logic go);
    vec_t t;
    t.btn   = btn;
    t.ready = rdy;
    t.sizes = sz;
    t.exp   = pack(v, sp, sc, mp, mc, pl, go);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = {move_valid, sel_pile, sel_count, move_pile, move_count, cur_player, game_over};
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b required %b (v,sp,sc,mp,mc,pl,go)", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] btn, input logic rdy, input logic [11:0] sz);
    @(negedge clk);
    btn_lvl    = btn;
    move_ready = rdy;
    pile_sizes = sz;
    @(posedge clk);
    #1;
  endtask

  localparam logic [11:0] SZ_A = 12'h753;  // pile0=3 pile1=5 pile2=7
  localparam logic [11:0] SZ_B = 12'h703;  // pile1 empty
  localparam logic [11:0] SZ_C = 12'h903;  // pile2=9, above MAX_TAKE
  localparam logic [11:0] SZ_Z = 12'h000;

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    reset_n    = 1'b0;
    btn_lvl    = 4'b0100;
    move_ready = 1'b0;
    pile_sizes = SZ_A;

    // Confirm held through reset must not register as a press.
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0, SZ_A);
      check("held_confirm", pack(0, 0, 0, 0, 0, 0, 0));
    end
    step(4'b0000, 1'b0, SZ_A);
    check("release", pack(0, 0, 0, 0, 0, 0, 0));

    // pile select and wrap
    add(4'b0001, 0, SZ_A, 0, 1, 0, 0, 0, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 1, 0, 0, 0, 0, 0);
    add(4'b0001, 0, SZ_A, 0, 2, 0, 0, 0, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 2, 0, 0, 0, 0, 0);
    add(4'b0001, 0, SZ_A, 0, 0, 0, 0, 0, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 0, 0, 0, 0, 0, 0);
    // count 1,2,3,1 within pile0 size 3
    add(4'b0100, 0, SZ_A, 0, 0, 1, 0, 0, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 0, 1, 0, 0, 0, 0);
    add(4'b0010, 0, SZ_A, 0, 0, 2, 0, 0, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 0, 2, 0, 0, 0, 0);
    add(4'b0010, 0, SZ_A, 0, 0, 3, 0, 0, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 0, 3, 0, 0, 0, 0);
    add(4'b0010, 0, SZ_A, 0, 0, 1, 0, 0, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 0, 1, 0, 0, 0, 0);
    add(4'b0001, 0, SZ_A, 0, 0, 1, 0, 0, 0, 0);  // pile ignored in COUNT
    add(4'b0000, 0, SZ_A, 0, 0, 1, 0, 0, 0, 0);
    add(4'b0100, 0, SZ_A, 1, 0, 1, 0, 1, 0, 0);  // issue
    add(4'b0000, 0, SZ_A, 1, 0, 1, 0, 1, 0, 0);
    // ISSUE ignores every button while not ready
    add(4'b1111, 0, SZ_A, 1, 0, 1, 0, 1, 0, 0);
    add(4'b0000, 0, SZ_A, 1, 0, 1, 0, 1, 0, 0);
    add(4'b1111, 0, SZ_A, 1, 0, 1, 0, 1, 0, 0);
    add(4'b0000, 0, SZ_A, 1, 0, 1, 0, 1, 0, 0);
    add(4'b1000, 0, SZ_A, 1, 0, 1, 0, 1, 0, 0);
    add(4'b0000, 1, SZ_A, 0, 0, 0, 0, 1, 1, 0);  // accept
    add(4'b0000, 1, SZ_A, 0, 0, 0, 0, 1, 1, 0);  // ready without valid
    // confirm beats take, pre-press count issued
    add(4'b0001, 0, SZ_A, 0, 1, 0, 0, 1, 1, 0);
    add(4'b0000, 0, SZ_A, 0, 1, 0, 0, 1, 1, 0);
    add(4'b0100, 0, SZ_A, 0, 1, 1, 0, 1, 1, 0);
    add(4'b0000, 0, SZ_A, 0, 1, 1, 0, 1, 1, 0);
    add(4'b0010, 0, SZ_A, 0, 1, 2, 0, 1, 1, 0);
    add(4'b0000, 0, SZ_A, 0, 1, 2, 0, 1, 1, 0);
    add(4'b0110, 0, SZ_A, 1, 1, 2, 1, 2, 1, 0);
    add(4'b0000, 0, SZ_A, 1, 1, 2, 1, 2, 1, 0);
    add(4'b0000, 1, SZ_A, 0, 1, 0, 1, 2, 0, 0);
    // cancel beats confirm
    add(4'b0100, 0, SZ_A, 0, 1, 1, 1, 2, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 1, 1, 1, 2, 0, 0);
    add(4'b1100, 0, SZ_A, 0, 1, 0, 1, 2, 0, 0);
    add(4'b0000, 0, SZ_A, 0, 1, 0, 1, 2, 0, 0);
    add(4'b1000, 0, SZ_A, 0, 1, 0, 1, 2, 0, 0);  // cancel in SELECT
    add(4'b0010, 0, SZ_A, 0, 1, 0, 1, 2, 0, 0);  // take in SELECT
    add(4'b0000, 0, SZ_A, 0, 1, 0, 1, 2, 0, 0);
    // confirm on an empty pile
    add(4'b0000, 0, SZ_B, 0, 1, 0, 1, 2, 0, 0);
    add(4'b0100, 0, SZ_B, 0, 1, 0, 1, 2, 0, 0);
    add(4'b0000, 0, SZ_B, 0, 1, 0, 1, 2, 0, 0);
    // count clamps at MAX_TAKE on a larger pile
    add(4'b0001, 0, SZ_C, 0, 2, 0, 1, 2, 0, 0);
    add(4'b0000, 0, SZ_C, 0, 2, 0, 1, 2, 0, 0);
    add(4'b0100, 0, SZ_C, 0, 2, 1, 1, 2, 0, 0);
    add(4'b0000, 0, SZ_C, 0, 2, 1, 1, 2, 0, 0);
    for (int k = 2; k <= 8; k++) begin
      logic [3:0] c;
      c = (k == 8) ? 4'd1 : 4'(k);
      add(4'b0010, 0, SZ_C, 0, 2, c, 1, 2, 0, 0);
      add(4'b0000, 0, SZ_C, 0, 2, c, 1, 2, 0, 0);
    end
    add(4'b1000, 0, SZ_C, 0, 2, 0, 1, 2, 0, 0);
    add(4'b0000, 0, SZ_C, 0, 2, 0, 1, 2, 0, 0);
    // all piles empty
    add(4'b0000, 0, SZ_Z, 0, 2, 0, 1, 2, 0, 1);
    add(4'b0100, 0, SZ_Z, 0, 2, 0, 1, 2, 0, 1);
    add(4'b0000, 0, SZ_Z, 0, 2, 0, 1, 2, 0, 1);
    add(4'b0000, 0, SZ_A, 0, 2, 0, 1, 2, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].btn, vecs[i].ready, vecs[i].sizes);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Async reset in the middle of ISSUE drops the move.
    step(4'b0100, 1'b0, SZ_A);
    check("pre_abort_count", pack(0, 2, 1, 1, 2, 0, 0));
    step(4'b0000, 1'b0, SZ_A);
    step(4'b0100, 1'b0, SZ_A);
    check("pre_abort_issue", pack(1, 2, 1, 2, 1, 0, 0));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_abort", pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    btn_lvl = 4'b0000;
    move_ready = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b1, SZ_A);
      check("post_abort_idle", pack(0, 0, 0, 0, 0, 0, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
